// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI responder clocked entirely by sys_clk. cs, sclk and mosi are brought in
//   through 2-FF synchronizers; sclk edges are detected on the synchronized copy.
//   Bytes are shifted MSB first. Received bytes are presented on rx_data with a
//   one-cycle rx_valid strobe; transmit bytes come from a 1-deep holding buffer.
//
// Parameters
//   CPOL     sclk idle level
//   CPHA     0: sample on leading edge, 1: sample on trailing edge
//   TX_FILL  byte shifted out when the holding buffer is empty at byte start
//
// Ports
//   sys_clk      system clock, all logic on posedge
//   sys_rst      synchronous active-high reset
//   cs           chip select (active low, asynchronous)
//   sclk         SPI clock (asynchronous)
//   mosi         master-out data (asynchronous)
//   miso         slave-out data, MSB of the transmit shift register
//   miso_oe      pad enable, high while synchronized cs is low
//   tx_data      byte to transmit
//   tx_valid     tx_data valid, accepted when tx_valid & tx_ready
//   tx_ready     holding buffer empty
//   rx_data      last received byte
//   rx_valid     one-cycle strobe, rx_data updated in the same cycle
//   busy         frame active
//   frame_err    one-cycle strobe, cs rose in the middle of a byte
//   tx_underrun  one-cycle strobe, TX_FILL substituted at a byte start
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter logic       CPOL    = 1'b1,
    parameter logic       CPHA    = 1'b1,
    parameter logic [7:0] TX_FILL = 8'h00
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       tx_underrun
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t     state, state_nxt;

    logic       cs_meta, cs_sync, cs_prev;
    logic       sclk_meta, sclk_sync, sclk_prev;
    logic       mosi_meta, mosi_sync;
    logic [1:0] settle_cnt;
    logic       settled;

    logic [7:0] shreg;
    logic [6:0] rx_sh;
    logic [2:0] bit_cnt;
    logic [7:0] buf_data;
    logic       buf_full;

    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       cs_fall, in_frame, reload, tx_accept;

    // The synchronizers come out of reset holding artificial values (cs=1).
    // cs_prev is only fed once the chain carries real samples, so a cs that was
    // already low across a reset does not look like a fresh falling edge.
    assign settled     = (settle_cnt == 2'd2);
    assign cs_fall     = cs_prev & ~cs_sync;

    assign lead_edge   = (sclk_prev == CPOL) && (sclk_sync != CPOL);
    assign trail_edge  = (sclk_prev != CPOL) && (sclk_sync == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign in_frame    = (state == SHIFT) && !cs_sync;
    assign tx_accept   = tx_valid & ~buf_full;

    // Byte start: the LOAD cycle, then every byte boundary. With CPHA=1 the next
    // byte is loaded on the 8th sample edge; with CPHA=0 on the trailing edge
    // that follows it (the only shift edge seen with bit_cnt == 0).
    assign reload = (state == LOAD) ||
                    (in_frame && (CPHA ? (sample_edge && bit_cnt == 3'd7)
                                       : (shift_edge  && bit_cnt == 3'd0)));

    assign miso     = shreg[7];
    assign miso_oe  = ~cs_sync;
    assign tx_ready = ~buf_full;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = LOAD;
            LOAD:    state_nxt = cs_sync ? IDLE : SHIFT;
            SHIFT:   if (cs_sync) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_meta     <= 1'b1;
            cs_sync     <= 1'b1;
            cs_prev     <= 1'b0;
            sclk_meta   <= CPOL;
            sclk_sync   <= CPOL;
            sclk_prev   <= CPOL;
            mosi_meta   <= 1'b0;
            mosi_sync   <= 1'b0;
            settle_cnt  <= '0;
            state       <= IDLE;
            shreg       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            if (!settled) settle_cnt <= settle_cnt + 2'd1;
            cs_prev   <= settled & cs_sync;

            state       <= state_nxt;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            // A byte accepted on a reload cycle into an empty buffer is not
            // bypassed into shreg; the reload sees the old (empty) buffer.
            if (tx_accept) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end else if (reload && buf_full) begin
                buf_full <= 1'b0;
            end

            // bit_cnt == 0 on a shift edge is either the reload edge (CPHA=0)
            // or the first leading edge of a byte (CPHA=1), never a shift.
            if (reload) begin
                if (buf_full) begin
                    shreg <= buf_data;
                end else begin
                    shreg       <= TX_FILL;
                    tx_underrun <= 1'b1;
                end
            end else if (in_frame && shift_edge && bit_cnt != 3'd0) begin
                shreg <= {shreg[6:0], 1'b0};
            end

            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state != IDLE && cs_sync) begin
                frame_err <= (bit_cnt != 3'd0);
                bit_cnt   <= '0;
            end else if (in_frame && sample_edge) begin
                rx_sh <= {rx_sh[5:0], mosi_sync};
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_sh, mosi_sync};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule
